ysyx_22040759_rd_arbiter: RTL and testbench

- Two-master read arbiter placed directly upstream of the AXI read master (rdaxi).
- Accepts instruction-fetch (IF) and load (MEM) read requests and grants one at a time.
- Issues a single-cycle request pulse with stable address and size to the read master.
- Routes returned data back to the granted requester, applying load sign or zero extension and IF flush suppression.

---
 rtl/ysyx_22040759_rd_arbiter_pkg.sv | 26 ++
 rtl/ysyx_22040759_rd_arbiter_if.sv | 42 ++++
 rtl/ysyx_22040759_ld_ext.sv | 19 +
 rtl/ysyx_22040759_rd_arbiter.sv | 125 ++++++++++++
 tb/tb_ysyx_22040759_rd_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22040759_rd_arbiter_pkg.sv
// Shared definitions for the IF/MEM read arbiter: access sizes, FSM states, owner codes.
package ysyx_22040759_rd_arbiter_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    // Instructions are 32 bits; the upper half of the returned word is discarded.
    function automatic logic [63:0] fetch_word(input logic [63:0] d);
        return {32'b0, d[31:0]};
    endfunction

endpackage

// File: rtl/ysyx_22040759_rd_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the arbiter and the AXI read master.
// Signal suffixes are from the arbiter's point of view (slave modport).
interface ysyx_22040759_rd_arbiter_if #(
    parameter int ADDR_WIDTH = 64
) ();
    logic                  if_req_valid_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic                  if_flush_i;
    logic                  if_data_valid_o;
    logic [63:0]           if_data_o;

    logic                  mem_req_valid_i;
    logic [ADDR_WIDTH-1:0] mem_addr_i;
    logic [1:0]            mem_size_i;
    logic                  mem_signed_i;
    logic                  mem_data_valid_o;
    logic [63:0]           mem_data_o;

    logic                  rd_addr_valid_o;
    logic [ADDR_WIDTH-1:0] rd_addr_o;
    logic [1:0]            rd_size_o;
    logic                  rd_data_valid_i;
    logic [63:0]           rd_data_i;

    modport slave (
        input  if_req_valid_i, if_addr_i, if_flush_i,
        output if_data_valid_o, if_data_o,
        input  mem_req_valid_i, mem_addr_i, mem_size_i, mem_signed_i,
        output mem_data_valid_o, mem_data_o,
        output rd_addr_valid_o, rd_addr_o, rd_size_o,
        input  rd_data_valid_i, rd_data_i
    );

    modport master (
        output if_req_valid_i, if_addr_i, if_flush_i,
        input  if_data_valid_o, if_data_o,
        output mem_req_valid_i, mem_addr_i, mem_size_i, mem_signed_i,
        input  mem_data_valid_o, mem_data_o,
        input  rd_addr_valid_o, rd_addr_o, rd_size_o,
        output rd_data_valid_i, rd_data_i
    );
endinterface

// File: rtl/ysyx_22040759_ld_ext.sv
// Load-data extender: right-aligned read data widened to 64 bits by access size.
module ysyx_22040759_ld_ext
    import ysyx_22040759_rd_arbiter_pkg::*;
(
    input  logic [63:0] data_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [63:0] data_o
);
    always_comb begin
        data_o = data_i;
        case (size_i)
            SIZE_B:  data_o = {{56{signed_i & data_i[7]}},  data_i[7:0]};
            SIZE_H:  data_o = {{48{signed_i & data_i[15]}}, data_i[15:0]};
            SIZE_W:  data_o = {{32{signed_i & data_i[31]}}, data_i[31:0]};
            default: data_o = data_i;
        endcase
    end
endmodule

// File: rtl/ysyx_22040759_rd_arbiter.sv
// Two-master (IF / MEM) read arbiter in front of the AXI read master.
// Define YSYX_22040759_ARB_RR_EN for round-robin; default is fixed MEM-over-IF priority.
module ysyx_22040759_rd_arbiter
    import ysyx_22040759_rd_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_22040759_rd_arbiter_if.slave   bus
);
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [1:0]            size;
        logic                  sgn;
        owner_e                owner;
    } req_t;

    arb_state_e            state_q;
    req_t                  req_q;
    req_t                  grant_d;
    logic                  flushed_q;
    logic                  rd_vld_q;
    logic                  if_vld_q;
    logic                  mem_vld_q;
    logic [DATA_WIDTH-1:0] if_data_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic [63:0]           ld_data;
    logic                  if_ok;
    logic                  mem_ok;
    logic                  pick_mem;
    logic                  flush_hit;

    // A flushed fetch must not win arbitration in the cycle it is cancelled.
    assign if_ok  = bus.if_req_valid_i & ~bus.if_flush_i;
    assign mem_ok = bus.mem_req_valid_i;

`ifdef YSYX_22040759_ARB_RR_EN
    owner_e last_grant_q;
    assign pick_mem = mem_ok & (~if_ok | (last_grant_q == OWN_IF));
`else
    assign pick_mem = mem_ok;
`endif

    always_comb begin
        grant_d = '{addr: bus.if_addr_i, size: SIZE_W, sgn: 1'b0, owner: OWN_IF};
        if (pick_mem)
            grant_d = '{addr: bus.mem_addr_i, size: bus.mem_size_i,
                        sgn: bus.mem_signed_i, owner: OWN_MEM};
    end

    assign flush_hit = bus.if_flush_i & (req_q.owner == OWN_IF);

    ysyx_22040759_ld_ext u_ld_ext (
        .data_i   (bus.rd_data_i),
        .size_i   (req_q.size),
        .signed_i (req_q.sgn),
        .data_o   (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            flushed_q  <= 1'b0;
            rd_vld_q   <= 1'b0;
            if_vld_q   <= 1'b0;
            mem_vld_q  <= 1'b0;
            if_data_q  <= '0;
            mem_data_q <= '0;
`ifdef YSYX_22040759_ARB_RR_EN
            last_grant_q <= OWN_IF;
`endif
        end else begin
            rd_vld_q  <= 1'b0;
            if_vld_q  <= 1'b0;
            mem_vld_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (if_ok | mem_ok) begin
                        req_q    <= grant_d;
                        rd_vld_q <= 1'b1;
                        state_q  <= ST_ISSUE;
`ifdef YSYX_22040759_ARB_RR_EN
                        last_grant_q <= grant_d.owner;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (flush_hit) flushed_q <= 1'b1;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (flush_hit) flushed_q <= 1'b1;
                    // The read always completes; a flushed fetch just drops its strobe.
                    if (bus.rd_data_valid_i) begin
                        state_q <= ST_RESP;
                        if (req_q.owner == OWN_MEM) begin
                            mem_vld_q  <= 1'b1;
                            mem_data_q <= ld_data;
                        end else if (!(flushed_q | bus.if_flush_i)) begin
                            if_vld_q  <= 1'b1;
                            if_data_q <= fetch_word(bus.rd_data_i);
                        end
                    end
                end
                ST_RESP: begin
                    flushed_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.rd_addr_valid_o  = rd_vld_q;
    assign bus.rd_addr_o        = req_q.addr;
    assign bus.rd_size_o        = req_q.size;
    assign bus.if_data_valid_o  = if_vld_q;
    assign bus.if_data_o        = if_data_q;
    assign bus.mem_data_valid_o = mem_vld_q;
    assign bus.mem_data_o       = mem_data_q;

endmodule

// File: tb/tb_ysyx_22040759_rd_arbiter.sv
// Self-checking bench for the IF/MEM read arbiter; the bench plays requesters and read master.
module tb_ysyx_22040759_rd_arbiter;
    import ysyx_22040759_rd_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22040759_rd_arbiter_if #(.ADDR_WIDTH(64)) bus ();

    ysyx_22040759_rd_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    bit          m_last_mem = 1'b0;
    logic [63:0] m_if_data  = '0;
    logic [63:0] m_mem_data = '0;

    // Protocol monitors
    int   consec_viol = 0, both_strobe = 0, if_strobes = 0, mem_strobes = 0, av_count = 0;
    logic prev_av = 1'b0;
    always @(negedge clk) begin
        if (bus.rd_addr_valid_o === 1'b1 && prev_av === 1'b1) consec_viol++;
        prev_av = bus.rd_addr_valid_o;
        if (bus.rd_addr_valid_o === 1'b1) av_count++;
        if (bus.if_data_valid_o === 1'b1 && bus.mem_data_valid_o === 1'b1) both_strobe++;
        if (bus.if_data_valid_o === 1'b1) if_strobes++;
        if (bus.mem_data_valid_o === 1'b1) mem_strobes++;
    end

    function automatic bit m_pick_mem(bit memv, bit ifv);
        if (!memv) return 1'b0;
        if (!ifv) return 1'b1;
`ifdef YSYX_22040759_ARB_RR_EN
        return !m_last_mem;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [63:0] m_ext(logic [63:0] d, logic [1:0] sz, bit sg);
        int nb;
        logic [63:0] mask, v;
        nb = 8 << sz;
        if (nb == 64) return d;
        mask = (64'd1 << nb) - 64'd1;
        v = d & mask;
        if (sg && d[nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [63:0] m_if(logic [63:0] d);
        return d & 64'h0000_0000_FFFF_FFFF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req_valid_i  = 1'b0;
        bus.if_addr_i       = '0;
        bus.if_flush_i      = 1'b0;
        bus.mem_req_valid_i = 1'b0;
        bus.mem_addr_i      = '0;
        bus.mem_size_i      = '0;
        bus.mem_signed_i    = 1'b0;
        bus.rd_data_valid_i = 1'b0;
        bus.rd_data_i       = '0;
    endtask

    task automatic wait_issue(output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        while (cyc < 20 && !seen) begin
            step();
            cyc++;
            if (bus.rd_addr_valid_o === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic respond(input logic [63:0] d);
        bus.rd_data_valid_i = 1'b1;
        bus.rd_data_i       = d;
        step();
        bus.rd_data_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) step();
        n_total++;
        if ({bus.rd_addr_valid_o, bus.if_data_valid_o, bus.mem_data_valid_o} !== 3'b000)
            $display("FAIL reset_strobes: got %b want 000",
                     {bus.rd_addr_valid_o, bus.if_data_valid_o, bus.mem_data_valid_o});
        else n_pass++;
        n_total++;
        if ({bus.if_data_o, bus.mem_data_o, bus.rd_addr_o, bus.rd_size_o} !== '0)
            $display("FAIL reset_data: if=%h mem=%h addr=%h size=%b want all 0",
                     bus.if_data_o, bus.mem_data_o, bus.rd_addr_o, bus.rd_size_o);
        else n_pass++;
        rst = 1'b0;
        m_last_mem = 1'b0;
        m_if_data  = '0;
        m_mem_data = '0;
        step();
    endtask

    task automatic test_mem_only();
        bit seen; int cyc;
        logic [63:0] exp;
        bus.mem_req_valid_i = 1'b1;
        bus.mem_addr_i      = 64'h8000_0004;
        bus.mem_size_i      = SIZE_H;
        bus.mem_signed_i    = 1'b1;
        m_last_mem = m_pick_mem(1, 0);
        wait_issue(seen, cyc);
        n_total++;
        if (!seen || cyc != 1) $display("FAIL mem_issue_latency: seen=%0d cyc=%0d want 1/1", seen, cyc);
        else n_pass++;
        n_total++;
        if (bus.rd_addr_o !== 64'h8000_0004 || bus.rd_size_o !== 2'b01)
            $display("FAIL mem_issue_fields: addr=%h size=%b want 80000004/01", bus.rd_addr_o, bus.rd_size_o);
        else n_pass++;
        step();
        n_total++;
        if (bus.rd_addr_valid_o !== 1'b0 || bus.rd_addr_o !== 64'h8000_0004)
            $display("FAIL mem_issue_pulse: valid=%b addr=%h want 0/80000004", bus.rd_addr_valid_o, bus.rd_addr_o);
        else n_pass++;
        step();
        respond(64'h8001);
        exp = m_ext(64'h8001, SIZE_H, 1'b1);
        m_mem_data = exp;
        n_total++;
        if (bus.mem_data_valid_o !== 1'b1 || bus.mem_data_o !== exp || bus.if_data_valid_o !== 1'b0)
            $display("FAIL mem_lh_data: vld=%b data=%h ifv=%b want 1/%h/0",
                     bus.mem_data_valid_o, bus.mem_data_o, bus.if_data_valid_o, exp);
        else n_pass++;
        bus.mem_req_valid_i = 1'b0;
        step();
        n_total++;
        if (bus.mem_data_valid_o !== 1'b0 || bus.mem_data_o !== m_mem_data)
            $display("FAIL mem_hold: vld=%b data=%h want 0/%h", bus.mem_data_valid_o, bus.mem_data_o, m_mem_data);
        else n_pass++;
    endtask

    task automatic test_if_only();
        bit seen; int cyc, s0;
        bus.if_req_valid_i = 1'b1;
        bus.if_addr_i      = 64'h8000_0000;
        m_last_mem = m_pick_mem(0, 1);
        wait_issue(seen, cyc);
        n_total++;
        if (!seen || bus.rd_addr_o !== 64'h8000_0000 || bus.rd_size_o !== SIZE_W)
            $display("FAIL if_issue: seen=%0d addr=%h size=%b want 1/80000000/10", seen, bus.rd_addr_o, bus.rd_size_o);
        else n_pass++;
        s0 = if_strobes;
        step();
        respond(64'hDEAD_BEEF_0000_0013);
        m_if_data = m_if(64'hDEAD_BEEF_0000_0013);
        n_total++;
        if (bus.if_data_valid_o !== 1'b1 || bus.if_data_o !== m_if_data)
            $display("FAIL if_data: vld=%b data=%h want 1/%h", bus.if_data_valid_o, bus.if_data_o, m_if_data);
        else n_pass++;
        bus.if_req_valid_i = 1'b0;
        step();
        step();
        n_total++;
        if (if_strobes - s0 != 1) $display("FAIL if_single_pulse: got %0d strobes want 1", if_strobes - s0);
        else n_pass++;
    endtask

    task automatic test_both();
        bit seen, w; int cyc;
        logic [63:0] d, exp;
        bus.mem_req_valid_i = 1'b1;
        bus.mem_addr_i      = 64'h1000;
        bus.mem_size_i      = SIZE_W;
        bus.mem_signed_i    = 1'b1;
        bus.if_req_valid_i  = 1'b1;
        bus.if_addr_i       = 64'h2000;
        for (int k = 0; k < 2; k++) begin
            w = m_pick_mem(bus.mem_req_valid_i, bus.if_req_valid_i);
            m_last_mem = w;
            wait_issue(seen, cyc);
            n_total++;
            if (!seen || (k == 1 && cyc != 2))
                $display("FAIL both_issue_timing%0d: seen=%0d cyc=%0d want 1/2", k, seen, cyc);
            else n_pass++;
            n_total++;
            if (bus.rd_addr_o !== (w ? 64'h1000 : 64'h2000))
                $display("FAIL both_grant%0d: addr=%h want %h", k, bus.rd_addr_o, w ? 64'h1000 : 64'h2000);
            else n_pass++;
            step();
            d = {$urandom, $urandom};
            respond(d);
            exp = w ? m_ext(d, SIZE_W, 1'b1) : m_if(d);
            n_total++;
            if ((w ? bus.mem_data_valid_o : bus.if_data_valid_o) !== 1'b1 ||
                (w ? bus.mem_data_o : bus.if_data_o) !== exp)
                $display("FAIL both_data%0d: mem=%b/%h if=%b/%h want %h", k, bus.mem_data_valid_o,
                         bus.mem_data_o, bus.if_data_valid_o, bus.if_data_o, exp);
            else n_pass++;
            if (w) begin bus.mem_req_valid_i = 1'b0; m_mem_data = exp; end
            else   begin bus.if_req_valid_i  = 1'b0; m_if_data  = exp; end
        end
        step();
    endtask

    task automatic test_hold_both();
        bit seen, w;
        int cyc;
        logic [63:0] d, exp;
        bus.mem_req_valid_i = 1'b1;
        bus.mem_addr_i      = 64'h4000;
        bus.mem_size_i      = SIZE_B;
        bus.mem_signed_i    = 1'b0;
        bus.if_req_valid_i  = 1'b1;
        bus.if_addr_i       = 64'h5000;
        for (int k = 0; k < 4; k++) begin
            w = m_pick_mem(1, 1);
            m_last_mem = w;
            wait_issue(seen, cyc);
            n_total++;
            if (!seen || bus.rd_addr_o !== (w ? 64'h4000 : 64'h5000))
                $display("FAIL hold_grant%0d: seen=%0d addr=%h want %h", k, seen, bus.rd_addr_o, w ? 64'h4000 : 64'h5000);
            else n_pass++;
            step();
            d = {$urandom, $urandom};
            respond(d);
            exp = w ? m_ext(d, SIZE_B, 1'b0) : m_if(d);
            n_total++;
            if (bus.mem_data_valid_o !== w || bus.if_data_valid_o !== !w ||
                (w ? bus.mem_data_o : bus.if_data_o) !== exp)
                $display("FAIL hold_data%0d: memv=%b ifv=%b mem=%h if=%h want owner_mem=%0d data %h", k,
                         bus.mem_data_valid_o, bus.if_data_valid_o, bus.mem_data_o, bus.if_data_o, w, exp);
            else n_pass++;
            if (w) m_mem_data = exp; else m_if_data = exp;
        end
        bus.mem_req_valid_i = 1'b0;
        bus.if_req_valid_i  = 1'b0;
        step();
    endtask

    task automatic test_flush();
        bit seen;
        int cyc, s0;
        logic [63:0] d;
        // Flush in IDLE: the fetch is not granted that cycle.
        bus.if_req_valid_i = 1'b1;
        bus.if_addr_i      = 64'h3000;
        bus.if_flush_i     = 1'b1;
        step();
        n_total++;
        if (bus.rd_addr_valid_o !== 1'b0) $display("FAIL flush_idle: valid=%b want 0", bus.rd_addr_valid_o);
        else n_pass++;
        bus.if_flush_i = 1'b0;
        // Flush while waiting for the read.
        m_last_mem = m_pick_mem(0, 1);
        wait_issue(seen, cyc);
        step();
        bus.if_flush_i = 1'b1;
        step();
        bus.if_flush_i     = 1'b0;
        bus.if_req_valid_i = 1'b0;
        s0 = if_strobes;
        respond({$urandom, $urandom});
        n_total++;
        if (bus.if_data_valid_o !== 1'b0) $display("FAIL flush_wait_strobe: got %b want 0", bus.if_data_valid_o);
        else n_pass++;
        step();
        step();
        n_total++;
        if (if_strobes != s0 || bus.if_data_o !== m_if_data)
            $display("FAIL flush_wait_hold: strobes=%0d data=%h want 0/%h", if_strobes - s0, bus.if_data_o, m_if_data);
        else n_pass++;
        // A load right after the flushed fetch completes normally.
        bus.mem_req_valid_i = 1'b1;
        bus.mem_addr_i      = 64'h6008;
        bus.mem_size_i      = SIZE_D;
        bus.mem_signed_i    = 1'b0;
        m_last_mem = m_pick_mem(1, 0);
        wait_issue(seen, cyc);
        n_total++;
        if (!seen || bus.rd_addr_o !== 64'h6008 || bus.rd_size_o !== SIZE_D)
            $display("FAIL flush_next_mem_issue: seen=%0d addr=%h size=%b", seen, bus.rd_addr_o, bus.rd_size_o);
        else n_pass++;
        step();
        d = {$urandom, $urandom};
        respond(d);
        m_mem_data = m_ext(d, SIZE_D, 1'b0);
        n_total++;
        if (bus.mem_data_valid_o !== 1'b1 || bus.mem_data_o !== m_mem_data)
            $display("FAIL flush_next_mem_data: vld=%b data=%h want 1/%h", bus.mem_data_valid_o, bus.mem_data_o, m_mem_data);
        else n_pass++;
        bus.mem_req_valid_i = 1'b0;
        // Flush coinciding with the data strobe.
        bus.if_req_valid_i = 1'b1;
        bus.if_addr_i      = 64'h3100;
        m_last_mem = m_pick_mem(0, 1);
        wait_issue(seen, cyc);
        step();
        s0 = if_strobes;
        bus.if_flush_i = 1'b1;
        respond({$urandom, $urandom});
        bus.if_flush_i     = 1'b0;
        bus.if_req_valid_i = 1'b0;
        step();
        step();
        n_total++;
        if (if_strobes != s0 || bus.if_data_o !== m_if_data)
            $display("FAIL flush_same_cycle: strobes=%0d data=%h want 0/%h", if_strobes - s0, bus.if_data_o, m_if_data);
        else n_pass++;
    endtask

    task automatic test_rst_wait();
        bit seen;
        int cyc, si, sm, sa;
        bus.mem_req_valid_i = 1'b1;
        bus.mem_addr_i      = 64'h7000;
        bus.mem_size_i      = SIZE_W;
        bus.mem_signed_i    = 1'b0;
        wait_issue(seen, cyc);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.mem_req_valid_i = 1'b0;
        m_last_mem = 1'b0;
        m_if_data  = '0;
        m_mem_data = '0;
        n_total++;
        if ({bus.rd_addr_valid_o, bus.if_data_valid_o, bus.mem_data_valid_o, bus.if_data_o,
             bus.mem_data_o, bus.rd_addr_o, bus.rd_size_o} !== '0)
            $display("FAIL rst_wait_outputs: av=%b ifv=%b memv=%b mem=%h addr=%h want all 0",
                     bus.rd_addr_valid_o, bus.if_data_valid_o, bus.mem_data_valid_o, bus.mem_data_o, bus.rd_addr_o);
        else n_pass++;
        si = if_strobes; sm = mem_strobes; sa = av_count;
        respond({$urandom, $urandom});
        repeat (3) step();
        n_total++;
        if (if_strobes != si || mem_strobes != sm || av_count != sa || bus.mem_data_o !== 64'h0)
            $display("FAIL rst_late_data: ifs=%0d mems=%0d issues=%0d mem=%h want 0/0/0/0",
                     if_strobes - si, mem_strobes - sm, av_count - sa, bus.mem_data_o);
        else n_pass++;
    endtask

    task automatic test_random();
        bit seen, w, memv, ifv, sg;
        int cyc, mode;
        logic [63:0] ma, ia, d, exp;
        logic [1:0] sz;
        for (int it = 0; it < 30; it++) begin
            mode = $urandom_range(0, 2);
            memv = (mode != 1);
            ifv  = (mode != 0);
            ma = {$urandom, $urandom};
            ia = {$urandom, $urandom};
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            bus.mem_req_valid_i = memv;
            bus.mem_addr_i      = ma;
            bus.mem_size_i      = sz;
            bus.mem_signed_i    = sg;
            bus.if_req_valid_i  = ifv;
            bus.if_addr_i       = ia;
            while (memv || ifv) begin
                w = m_pick_mem(memv, ifv);
                m_last_mem = w;
                wait_issue(seen, cyc);
                n_total++;
                if (!seen || bus.rd_addr_o !== (w ? ma : ia) || bus.rd_size_o !== (w ? sz : SIZE_W))
                    $display("FAIL rand_issue%0d: seen=%0d addr=%h size=%b want %h/%b", it, seen,
                             bus.rd_addr_o, bus.rd_size_o, w ? ma : ia, w ? sz : SIZE_W);
                else n_pass++;
                step();
                repeat ($urandom_range(0, 3)) step();
                d = {$urandom, $urandom};
                respond(d);
                exp = w ? m_ext(d, sz, sg) : m_if(d);
                n_total++;
                if (bus.mem_data_valid_o !== w || bus.if_data_valid_o !== !w ||
                    (w ? bus.mem_data_o : bus.if_data_o) !== exp)
                    $display("FAIL rand_data%0d: memv=%b ifv=%b mem=%h if=%h want owner_mem=%0d data %h", it,
                             bus.mem_data_valid_o, bus.if_data_valid_o, bus.mem_data_o, bus.if_data_o, w, exp);
                else n_pass++;
                if (w) begin memv = 1'b0; bus.mem_req_valid_i = 1'b0; end
                else   begin ifv  = 1'b0; bus.if_req_valid_i  = 1'b0; end
            end
        end
        step();
    endtask

    task automatic test_invariants();
        n_total++;
        if (consec_viol != 0) $display("FAIL addr_valid_back_to_back: got %0d want 0", consec_viol);
        else n_pass++;
        n_total++;
        if (both_strobe != 0) $display("FAIL both_strobes_high: got %0d want 0", both_strobe);
        else n_pass++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mem_only();
        test_if_only();
        test_both();
        test_hold_both();
        test_flush();
        test_rst_wait();
        test_random();
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
